rally_sequencer: RTL

Sequences the Pong game datapath while the main FSM has the game enabled. It resets and launches the ball, detects missed balls, updates both scores, holds a point-display pause, and declares the winner. It sits between the main FSM (which supplies enable_game and reset) and the ball/paddle datapath (which supplies miss events and obeys freeze/ball_reset/ball_launch). All timing counts frame ticks, not clocks.

---
 rtl/pong_pkg.sv | 18 +
 rtl/frame_countdown.sv | 40 ++++
 rtl/rally_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game blocks: rally state encodings and
// the side constants used by the main FSM, the rally sequencer and the datapath.
package pong_pkg;

    // Rally sequencer states (3-bit encoding; unused codes recover to IDLE)
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        OVER       = 3'd4
    } rally_state_t;

    // Side encoding shared by serve_dir and winner
    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame-tick down-counter shared by the serve delay and the point hold.
// load takes priority over enable; the counter never wraps below zero.
// done_next flags the enable pulse that finds the count at 1, i.e. the tick
// that completes the countdown.
module frame_countdown #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] value,
    input  logic                 enable,
    output logic                 done_next
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: reload wins, otherwise step down once per enable pulse
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_next = enable && (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/rally_sequencer.sv
// Pong rally sequencer: serves the ball, waits for misses, scores points,
// holds the field frozen between points and declares the winner.
// All delays are counted in qualified frame ticks (tick while the game is enabled).
module rally_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 4,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned POINT_HOLD  = 90,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   enable_game,
    input  logic                   miss_left,
    input  logic                   miss_right,
    output logic                   ball_reset,
    output logic                   ball_launch,
    output logic                   serve_dir,
    output logic                   freeze,
    output logic [SCORE_WIDTH-1:0] score_left,
    output logic [SCORE_WIDTH-1:0] score_right,
    output logic                   game_over,
    output logic                   winner
);

    localparam logic [SCORE_WIDTH-1:0] WIN_VALUE   = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [CNT_WIDTH-1:0]   SERVE_COUNT = CNT_WIDTH'(SERVE_DELAY);
    localparam logic [CNT_WIDTH-1:0]   HOLD_COUNT  = CNT_WIDTH'(POINT_HOLD);

    rally_state_t state_q;
    rally_state_t state_d;

    logic [SCORE_WIDTH-1:0] score_left_q;
    logic [SCORE_WIDTH-1:0] score_left_d;
    logic [SCORE_WIDTH-1:0] score_right_q;
    logic [SCORE_WIDTH-1:0] score_right_d;
    logic                   serve_dir_q;
    logic                   serve_dir_d;
    logic                   game_over_q;
    logic                   game_over_d;
    logic                   winner_q;
    logic                   winner_d;
    logic                   ball_reset_q;
    logic                   ball_reset_d;
    logic                   ball_launch_q;
    logic                   ball_launch_d;

    logic                   qual_tick;
    logic                   cnt_load;
    logic [CNT_WIDTH-1:0]   cnt_value;
    logic                   cnt_enable;
    logic                   cnt_done;

    // Ticks only count while the main FSM has the game running
    assign qual_tick  = tick && enable_game;
    assign cnt_enable = qual_tick && ((state_q == SERVE_WAIT) || (state_q == POINT));

    frame_countdown #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_countdown (
        .clock     (clock),
        .reset     (reset),
        .load      (cnt_load),
        .value     (cnt_value),
        .enable    (cnt_enable),
        .done_next (cnt_done)
    );

    // Next-state, scoring and one-clock pulse requests
    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        ball_reset_d  = 1'b0;
        ball_launch_d = 1'b0;
        cnt_load      = 1'b0;
        cnt_value     = '0;

        case (state_q)
            IDLE: begin
                if (enable_game) begin
                    cnt_load     = 1'b1;
                    cnt_value    = SERVE_COUNT;
                    ball_reset_d = 1'b1;
                    state_d      = SERVE_WAIT;
                end
            end

            SERVE_WAIT: begin
                if (cnt_done) begin
                    ball_launch_d = 1'b1;
                    state_d       = PLAY;
                end
            end

            PLAY: begin
                // Misses are ignored while paused
                if (enable_game) begin
                    if (miss_left && miss_right) begin
                        // Simultaneous misses: no point, just re-serve
                        cnt_load     = 1'b1;
                        cnt_value    = SERVE_COUNT;
                        ball_reset_d = 1'b1;
                        state_d      = SERVE_WAIT;
                    end else if (miss_left) begin
                        score_right_d = score_right_q + SCORE_WIDTH'(1);
                        serve_dir_d   = SIDE_LEFT;
                        cnt_load      = 1'b1;
                        cnt_value     = HOLD_COUNT;
                        state_d       = POINT;
                    end else if (miss_right) begin
                        score_left_d = score_left_q + SCORE_WIDTH'(1);
                        serve_dir_d  = SIDE_RIGHT;
                        cnt_load     = 1'b1;
                        cnt_value    = HOLD_COUNT;
                        state_d      = POINT;
                    end
                end
            end

            POINT: begin
                if (cnt_done) begin
                    if ((score_left_q == WIN_VALUE) || (score_right_q == WIN_VALUE)) begin
                        game_over_d = 1'b1;
                        winner_d    = (score_right_q == WIN_VALUE) ? SIDE_RIGHT : SIDE_LEFT;
                        state_d     = OVER;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_value    = SERVE_COUNT;
                        ball_reset_d = 1'b1;
                        state_d      = SERVE_WAIT;
                    end
                end
            end

            OVER: begin
                // Terminal until reset
            end

            default: begin
                // Illegal encoding: fall back to the reset picture
                state_d       = IDLE;
                score_left_d  = '0;
                score_right_d = '0;
                serve_dir_d   = SIDE_LEFT;
                game_over_d   = 1'b0;
                winner_d      = SIDE_LEFT;
                cnt_load      = 1'b1;
                cnt_value     = '0;
            end
        endcase
    end

    // State, score and pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= SIDE_LEFT;
            game_over_q   <= 1'b0;
            winner_q      <= SIDE_LEFT;
            ball_reset_q  <= 1'b0;
            ball_launch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            ball_reset_q  <= ball_reset_d;
            ball_launch_q <= ball_launch_d;
        end
    end

    assign ball_reset  = ball_reset_q;
    assign ball_launch = ball_launch_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    // Datapath may move only while actively playing
    assign freeze      = !((state_q == PLAY) && enable_game);

endmodule
